// File: rtl/iob_cache_line_fill.sv
// Cache line fill engine: issues one pipelined back-end read per line word
// (optionally critical-word-first with wrap-around), tracks returning data
// through a fixed-latency return pipe and streams words to the data memory.
module iob_cache_line_fill #(
  parameter  int ADDR_W      = 32,
  parameter  int BE_ADDR_W   = 32,
  parameter  int BE_DATA_W   = 32,
  parameter  int LINE2BE_W   = 2,
  parameter  int BE_RLAT     = 1,
  parameter  int CWF         = 1,
  localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8),
  localparam int IDX_W       = (LINE2BE_W > 0) ? LINE2BE_W : 1,
  localparam int LA_W        = ADDR_W - BE_NBYTES_W,
  localparam int CNT_W       = LINE2BE_W + 1,
  localparam int N           = 1 << LINE2BE_W
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic                 replace_valid_i,
  input  logic [LA_W-1:0]      replace_addr_i,
  output logic                 replace_o,
  output logic                 read_valid_o,
  output logic [IDX_W-1:0]     read_addr_o,
  output logic [BE_DATA_W-1:0] read_rdata_o,
  output logic                 crit_valid_o,
  output logic [BE_ADDR_W-1:0] be_addr_o,
  output logic                 be_valid_o,
  input  logic                 be_ready_i,
  input  logic [BE_DATA_W-1:0] be_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [LA_W-1:0]   line_addr;
  logic [LA_W-1:0]   word_addr;
  logic [IDX_W-1:0]  issue_idx;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic              fill_start;
  logic              accept;
  logic              issue_last;
  logic              ret_last;
  logic [BE_RLAT-1:0] ret_vld_p;
  logic [IDX_W-1:0]  ret_idx_p [BE_RLAT];

  assign fill_start = (state == IDLE) && replace_valid_i;
  assign accept     = be_valid_o && be_ready_i;
  assign issue_last = (issue_cnt == CNT_W'(N - 1));
  assign ret_last   = (ret_cnt == CNT_W'(N - 1));

  // State register
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and request/status outputs
  always_comb begin
    state_nxt  = state;
    replace_o  = 1'b1;
    be_valid_o = 1'b0;
    case (state)
      IDLE: begin
        replace_o = 1'b0;
        if (replace_valid_i) state_nxt = REQ;
      end
      REQ: begin
        be_valid_o = 1'b1;
        if (accept && issue_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (read_valid_o && ret_last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the miss address when a fill starts (data only, no reset)
  always_ff @(posedge clk_i) begin
    if (fill_start) line_addr <= replace_addr_i;
  end

  generate
    if (LINE2BE_W > 0) begin : g_idx
      logic [IDX_W-1:0] start_idx;

      // Latch the first word to fetch: critical word or word 0
      always_ff @(posedge clk_i) begin
        if (fill_start) start_idx <= (CWF != 0) ? replace_addr_i[IDX_W-1:0] : '0;
      end

      // Index wraps naturally at the line boundary through IDX_W-bit overflow
      assign issue_idx = start_idx + issue_cnt[IDX_W-1:0];
      assign word_addr = {line_addr[LA_W-1:LINE2BE_W], issue_idx};
    end else begin : g_noidx
      assign issue_idx = '0;
      assign word_addr = line_addr;
    end
  endgenerate

  // Back-end byte address: line tag, word index, zero byte offset
  always_comb begin
    be_addr_o              = '0;
    be_addr_o[ADDR_W-1:0]  = {word_addr, {BE_NBYTES_W{1'b0}}};
  end

  // Issue and return counters, cleared whenever the engine is idle
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (state == IDLE) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (accept)       issue_cnt <= issue_cnt + 1'b1;
      if (read_valid_o) ret_cnt   <= ret_cnt + 1'b1;
    end
  end

  // Return pipe: stage 0 captures each acceptance, last stage lines up with be_rdata_i
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      ret_vld_p <= '0;
      for (int i = 0; i < BE_RLAT; i++) ret_idx_p[i] <= '0;
    end else begin
      ret_vld_p[0] <= accept;
      ret_idx_p[0] <= issue_idx;
      for (int i = 1; i < BE_RLAT; i++) begin
        ret_vld_p[i] <= ret_vld_p[i-1];
        ret_idx_p[i] <= ret_idx_p[i-1];
      end
    end
  end

  // ---- return stage: last pipe entry pairs with back-end data ----
  assign read_valid_o = ret_vld_p[BE_RLAT-1];
  assign read_addr_o  = (LINE2BE_W > 0) ? ret_idx_p[BE_RLAT-1] : '0;
  assign read_rdata_o = be_rdata_i;
  assign crit_valid_o = read_valid_o && (ret_cnt == '0);

endmodule

// File: tb/tb_iob_cache_line_fill.sv
// Bench for iob_cache_line_fill: four differently configured instances, each
// exercised with directed and randomized fills and compared cycle by cycle
// against a queue-based model of request issue and fixed-latency returns.
module tb_iob_cache_line_fill;

  logic clk_i = 1'b0;
  logic reset;
  always #5 clk_i = ~clk_i;

  int sel;
  logic        rv;
  logic [29:0] raddr;
  logic        rdy;
  logic [31:0] rdata;

  logic        rep  [4];
  logic        rvld [4];
  logic        crit [4];
  logic        bev  [4];
  logic [31:0] bea  [4];
  logic [1:0]  ra   [4];
  logic [31:0] rd   [4];
  logic [1:0]  ra0, ra1, ra2;
  logic        ra3;

  int n_t [4] = '{4, 4, 4, 1};
  int r_t [4] = '{1, 1, 3, 2};
  int c_t [4] = '{1, 0, 1, 1};

  int passed = 0;
  int total  = 0;
  int nfail  = 0;

  iob_cache_line_fill #(.LINE2BE_W(2), .BE_RLAT(1), .CWF(1)) u0 (
    .clk_i(clk_i), .reset(reset), .replace_valid_i(rv && (sel == 0)), .replace_addr_i(raddr),
    .replace_o(rep[0]), .read_valid_o(rvld[0]), .read_addr_o(ra0), .read_rdata_o(rd[0]),
    .crit_valid_o(crit[0]), .be_addr_o(bea[0]), .be_valid_o(bev[0]), .be_ready_i(rdy),
    .be_rdata_i(rdata));
  iob_cache_line_fill #(.LINE2BE_W(2), .BE_RLAT(1), .CWF(0)) u1 (
    .clk_i(clk_i), .reset(reset), .replace_valid_i(rv && (sel == 1)), .replace_addr_i(raddr),
    .replace_o(rep[1]), .read_valid_o(rvld[1]), .read_addr_o(ra1), .read_rdata_o(rd[1]),
    .crit_valid_o(crit[1]), .be_addr_o(bea[1]), .be_valid_o(bev[1]), .be_ready_i(rdy),
    .be_rdata_i(rdata));
  iob_cache_line_fill #(.LINE2BE_W(2), .BE_RLAT(3), .CWF(1)) u2 (
    .clk_i(clk_i), .reset(reset), .replace_valid_i(rv && (sel == 2)), .replace_addr_i(raddr),
    .replace_o(rep[2]), .read_valid_o(rvld[2]), .read_addr_o(ra2), .read_rdata_o(rd[2]),
    .crit_valid_o(crit[2]), .be_addr_o(bea[2]), .be_valid_o(bev[2]), .be_ready_i(rdy),
    .be_rdata_i(rdata));
  iob_cache_line_fill #(.LINE2BE_W(0), .BE_RLAT(2), .CWF(1)) u3 (
    .clk_i(clk_i), .reset(reset), .replace_valid_i(rv && (sel == 3)), .replace_addr_i(raddr),
    .replace_o(rep[3]), .read_valid_o(rvld[3]), .read_addr_o(ra3), .read_rdata_o(rd[3]),
    .crit_valid_o(crit[3]), .be_addr_o(bea[3]), .be_valid_o(bev[3]), .be_ready_i(rdy),
    .be_rdata_i(rdata));

  assign ra[0] = ra0;
  assign ra[1] = ra1;
  assign ra[2] = ra2;
  assign ra[3] = {1'b0, ra3};

  logic        o_rep, o_rvld, o_crit, o_bev;
  logic [31:0] o_bea, o_rd;
  logic [1:0]  o_ra;

  // Present the selected instance's outputs to the checks
  always_comb begin
    o_rep  = rep[sel];
    o_rvld = rvld[sel];
    o_crit = crit[sel];
    o_bev  = bev[sel];
    o_bea  = bea[sel];
    o_rd   = rd[sel];
    o_ra   = ra[sel];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One fill on instance k. mode 0: ready always 1; 1: ready low on cycles slo..shi;
  // 2: random ready. abort_c>0 asserts reset in that cycle. cont: fill already
  // started by a held request. hold: keep request high with address nxt throughout.
  task automatic run_fill(input int k, input logic [31:0] baddr, input int mode,
                          input int slo, input int shi, input int abort_c,
                          input bit cont, input bit hold, input logic [31:0] nxt);
    int N, R, S, issued, rets, last_ret, c, widx;
    logic [31:0] base, mask;
    int due_c[$];
    int due_i[$];
    bit ready_c, exp_bev, exp_rv, exp_rep, done;
    N = n_t[k];
    R = r_t[k];
    S = (c_t[k] != 0) ? int'((baddr >> 2) % N) : 0;
    mask = 32'(N * 4 - 1);
    base = baddr & ~mask;
    sel = k;
    if (!cont) begin
      rv = 1'b1;
      raddr = baddr[31:2];
      @(negedge clk_i);
      chk("idle_replace_o", o_rep, 0);
      chk("idle_be_valid_o", o_bev, 0);
      @(posedge clk_i); #1;
    end
    issued = 0; rets = 0; last_ret = -10; done = 0;
    for (c = 1; !done; c++) begin
      if (c > 300) begin
        chk("timeout_returns", rets, N);
        break;
      end
      rv = hold;
      raddr = hold ? nxt[31:2] : 30'($urandom);
      if (mode == 0)      ready_c = 1'b1;
      else if (mode == 1) ready_c = !(c >= slo && c <= shi);
      else                ready_c = ($urandom_range(0, 3) != 0);
      rdy = ready_c;
      rdata = $urandom;
      if (c == abort_c) begin
        reset = 1'b1;
        #1;
        chk("abort_replace_o", o_rep, 0);
        chk("abort_be_valid_o", o_bev, 0);
        chk("abort_read_valid_o", o_rvld, 0);
        chk("abort_crit_valid_o", o_crit, 0);
        chk("abort_read_addr_o", o_ra, 0);
        @(posedge clk_i); #1;
        reset = 1'b0;
        rv = 1'b0;
        for (int j = 0; j < R + 3; j++) begin
          rdata = $urandom;
          @(negedge clk_i);
          chk("post_abort_read_valid_o", o_rvld, 0);
          chk("post_abort_replace_o", o_rep, 0);
          @(posedge clk_i); #1;
        end
        return;
      end
      exp_bev = (issued < N);
      exp_rv  = (due_c.size() > 0) && (due_c[0] == c);
      exp_rep = !((rets == N) && (c > last_ret + 1));
      @(negedge clk_i);
      chk("replace_o", o_rep, exp_rep);
      chk("be_valid_o", o_bev, exp_bev);
      if (exp_bev) chk("be_addr_o", o_bea, base + 32'(((S + issued) % N) * 4));
      chk("read_valid_o", o_rvld, exp_rv);
      if (exp_rv) begin
        widx = due_i.pop_front();
        void'(due_c.pop_front());
        chk("read_addr_o", o_ra, widx);
        chk("crit_valid_o", o_crit, (rets == 0));
        chk("read_rdata_o", o_rd, rdata);
        rets++;
        last_ret = c;
      end else begin
        chk("crit_valid_o_idle", o_crit, 0);
      end
      if (exp_bev && ready_c) begin
        due_c.push_back(c + R);
        due_i.push_back((S + issued) % N);
        issued++;
      end
      if (!exp_rep) done = 1;
      @(posedge clk_i); #1;
    end
    rv = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rv = 1'b0; raddr = '0; rdy = 1'b0; rdata = '0; sel = 0;
    @(posedge clk_i); @(posedge clk_i); #1;
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      chk("reset_replace_o", o_rep, 0);
      chk("reset_be_valid_o", o_bev, 0);
      chk("reset_read_valid_o", o_rvld, 0);
      chk("reset_crit_valid_o", o_crit, 0);
      chk("reset_read_addr_o", o_ra, 0);
    end
    reset = 1'b0;
    @(posedge clk_i); #1;

    run_fill(0, 32'h1008, 0, 0, 0, 0, 0, 0, 0);
    run_fill(1, 32'h1008, 0, 0, 0, 0, 0, 0, 0);
    run_fill(2, 32'h2004, 0, 0, 0, 0, 0, 0, 0);
    run_fill(2, 32'h2008, 1, 2, 3, 0, 0, 0, 0);
    run_fill(0, 32'h400C, 1, 2, 3, 0, 0, 0, 0);
    run_fill(0, 32'h1008, 0, 0, 0, 3, 0, 0, 0);
    run_fill(0, 32'h1008, 0, 0, 0, 0, 0, 0, 0);
    run_fill(2, 32'h2004, 0, 0, 0, 3, 0, 0, 0);
    run_fill(2, 32'h700C, 0, 0, 0, 0, 0, 0, 0);
    run_fill(3, 32'h300C, 0, 0, 0, 0, 0, 0, 0);
    run_fill(0, 32'h5004, 0, 0, 0, 0, 0, 1, 32'h6008);
    run_fill(0, 32'h6008, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      a = $urandom;
      a[1:0] = 2'b00;
      run_fill(int'($urandom_range(0, 3)), a, 2, 0, 0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
